// File: rtl/cpu_alu_x.sv
// cpu_alu_x -- single-issue integer ALU with a pipelined multiplier.
//
// Non-multiply opcodes complete one cycle after the accept cycle. Multiply
// opcodes (A..C) travel through an MPY_LATENCY-1 deep pipeline when
// MPY_LATENCY >= 2. Until that result emerges, o_busy is high and new
// requests are refused. i_abort empties the pipeline and suppresses the next
// o_valid.
//
// Ports:
//   i_clk    clock; all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_ce     accept strobe (ignored while o_busy or i_abort)
//   i_abort  flush any in-flight multiply
//   i_op     opcode, i_a / i_b operands
//   o_c      result, o_f flags {V,N,C,Z}; both hold while o_valid is low
//   o_valid  one-cycle completion pulse
//   o_busy   multiply in flight
module cpu_alu_x #(
  parameter int DW          = 32,
  parameter int MPY_LATENCY = 3,
  parameter bit OPT_EXTOPS  = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce,
  input  logic          i_abort,
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_c,
  output logic [3:0]    o_f,
  output logic          o_valid,
  output logic          o_busy
);

  localparam logic [3:0] OP_SUB    = 4'h0;
  localparam logic [3:0] OP_AND    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LSR    = 4'h5;
  localparam logic [3:0] OP_LSL    = 4'h6;
  localparam logic [3:0] OP_ASR    = 4'h7;
  localparam logic [3:0] OP_BREV   = 4'h8;
  localparam logic [3:0] OP_LODILO = 4'h9;
  localparam logic [3:0] OP_MPYUHI = 4'hA;
  localparam logic [3:0] OP_MPYSHI = 4'hB;
  localparam logic [3:0] OP_MPY    = 4'hC;
  localparam logic [3:0] OP_ROL    = 4'hD;
  localparam logic [3:0] OP_POPC   = 4'hE;

  localparam logic [DW-1:0] DW_VAL = DW'(DW);
  localparam bit            MPY_PIPE = (MPY_LATENCY >= 2);
  localparam int            PD = MPY_PIPE ? MPY_LATENCY - 1 : 1;

  function automatic logic [DW-1:0] f_brev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] f_popc(input logic [DW-1:0] v);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < DW; i++) n = n + {{(DW-1){1'b0}}, v[i]};
    return n;
  endfunction

  logic [DW:0]     add_s, sub_s, lsr_s, asr_s, lsl_s;
  logic [DW-1:0]   rol_amt_s, rol_s, res_s;
  logic [2*DW-1:0] mpy_a_s, mpy_b_s, prod_s;
  logic            mpy_sgn_s, v_s, c_s, n_s, addsub_s, is_mpy_s;
  logic [3:0]      flags_s;
  logic            accept_s, direct_s, busy_s, pipe_v_s;
  logic [DW-1:0]   pipe_c_s;
  logic [3:0]      pipe_f_s;
  logic [DW-1:0]   c_r;
  logic [3:0]      f_r;
  logic            valid_r;

  // Result and flag computation for the operation presented on the inputs.
  always_comb begin
    add_s = {1'b0, i_a} + {1'b0, i_b};
    sub_s = {1'b0, i_a} - {1'b0, i_b};
    // A guard bit below/above the operand catches the last bit shifted out;
    // shifts by the full unsigned b naturally saturate to 0 / all-sign.
    lsr_s = {i_a, 1'b0} >> i_b;
    asr_s = $signed({i_a, 1'b0}) >>> i_b;
    lsl_s = {1'b0, i_a} << i_b;
    rol_amt_s = i_b % DW_VAL;
    rol_s = (i_a << rol_amt_s) | (i_a >> (DW_VAL - rol_amt_s));
    // Sign-extending to 2*DW makes one unsigned multiply exact for both kinds.
    mpy_sgn_s = (i_op != OP_MPYUHI);
    mpy_a_s = {{DW{mpy_sgn_s & i_a[DW-1]}}, i_a};
    mpy_b_s = {{DW{mpy_sgn_s & i_b[DW-1]}}, i_b};
    prod_s = mpy_a_s * mpy_b_s;
    res_s = '0;
    c_s = 1'b0;
    v_s = 1'b0;
    case (i_op)
      OP_SUB: begin
        res_s = sub_s[DW-1:0];
        c_s = sub_s[DW];
        v_s = (i_a[DW-1] != i_b[DW-1]) & (sub_s[DW-1] != i_a[DW-1]);
      end
      OP_AND: res_s = i_a & i_b;
      OP_ADD: begin
        res_s = add_s[DW-1:0];
        c_s = add_s[DW];
        v_s = (i_a[DW-1] == i_b[DW-1]) & (add_s[DW-1] != i_a[DW-1]);
      end
      OP_OR:  res_s = i_a | i_b;
      OP_XOR: res_s = i_a ^ i_b;
      OP_LSR: begin
        res_s = lsr_s[DW:1];
        c_s = lsr_s[0];
        v_s = lsr_s[DW] ^ i_a[DW-1];
      end
      OP_LSL: begin
        res_s = lsl_s[DW-1:0];
        // A shift of exactly DW reports the operand sign bit as carry.
        c_s = (i_b == DW_VAL) ? i_a[DW-1] : lsl_s[DW];
        v_s = lsl_s[DW-1] ^ i_a[DW-1];
      end
      OP_ASR: begin
        res_s = asr_s[DW:1];
        c_s = asr_s[0];
      end
      OP_BREV:   res_s = f_brev(i_b);
      OP_LODILO: res_s = {i_a[DW-1:DW/2], i_b[DW/2-1:0]};
      OP_MPYUHI, OP_MPYSHI: res_s = (MPY_LATENCY == 0) ? '0 : prod_s[2*DW-1:DW];
      OP_MPY:    res_s = (MPY_LATENCY == 0) ? '0 : prod_s[DW-1:0];
      OP_ROL: begin
        if (OPT_EXTOPS) begin
          res_s = rol_s;
          c_s = rol_s[0];
        end else begin
          res_s = i_b;
        end
      end
      OP_POPC: begin
        if (OPT_EXTOPS) res_s = f_popc(i_b);
        else            res_s = i_b;
      end
      default: res_s = i_b;
    endcase
    addsub_s = (i_op == OP_ADD) | (i_op == OP_SUB);
    n_s = res_s[DW-1] ^ (addsub_s & v_s);
    flags_s = {v_s, n_s, c_s, (res_s == '0)};
    is_mpy_s = (i_op == OP_MPYUHI) | (i_op == OP_MPYSHI) | (i_op == OP_MPY);
  end

  assign accept_s = i_ce & ~i_abort & ~busy_s;
  assign direct_s = accept_s & ~(is_mpy_s & MPY_PIPE);

  if (MPY_PIPE) begin : g_pipe
    logic [PD-1:0] pv_r;
    logic [DW-1:0] pc_r [PD];
    logic [3:0]    pf_r [PD];
    logic          load_s;

    assign load_s = accept_s & is_mpy_s;

    // Multiply result pipeline; abort drops every in-flight valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        pv_r <= '0;
        for (int i = 0; i < PD; i++) begin
          pc_r[i] <= '0;
          pf_r[i] <= 4'h0;
        end
      end else if (i_abort) begin
        pv_r <= '0;
      end else begin
        pv_r[0] <= load_s;
        pc_r[0] <= res_s;
        pf_r[0] <= flags_s;
        for (int i = 1; i < PD; i++) begin
          pv_r[i] <= pv_r[i-1];
          pc_r[i] <= pc_r[i-1];
          pf_r[i] <= pf_r[i-1];
        end
      end
    end

    assign busy_s   = |pv_r;
    assign pipe_v_s = pv_r[PD-1];
    assign pipe_c_s = pc_r[PD-1];
    assign pipe_f_s = pf_r[PD-1];
  end else begin : g_nopipe
    assign busy_s   = 1'b0;
    assign pipe_v_s = 1'b0;
    assign pipe_c_s = '0;
    assign pipe_f_s = 4'h0;
  end

  // Output register: loads on direct completion or pipeline exit, else holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_r <= '0;
      f_r <= 4'h0;
      valid_r <= 1'b0;
    end else if (i_abort) begin
      valid_r <= 1'b0;
    end else if (direct_s) begin
      c_r <= res_s;
      f_r <= flags_s;
      valid_r <= 1'b1;
    end else if (pipe_v_s) begin
      c_r <= pipe_c_s;
      f_r <= pipe_f_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign o_c     = c_r;
  assign o_f     = f_r;
  assign o_valid = valid_r;
  assign o_busy  = busy_s;

endmodule

// File: tb/tb_cpu_alu_x.sv
module tb_cpu_alu_x;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce0 = 1'b0, ab0 = 1'b0;
  logic [3:0]  op0 = 4'h0;
  logic [31:0] a0 = 32'h0, b0 = 32'h0, c0;
  logic [3:0]  f0;
  logic        v0, bz0;

  logic        ce1 = 1'b0, ab1 = 1'b0;
  logic [3:0]  op1 = 4'h0;
  logic [15:0] a1 = 16'h0, b1 = 16'h0, c1;
  logic [3:0]  f1;
  logic        v1, bz1;

  logic        ce2 = 1'b0, ab2 = 1'b0;
  logic [3:0]  op2 = 4'h0;
  logic [15:0] a2 = 16'h0, b2 = 16'h0, c2;
  logic [3:0]  f2;
  logic        v2, bz2;

  cpu_alu_x #(.DW(32), .MPY_LATENCY(3), .OPT_EXTOPS(1'b1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce0), .i_abort(ab0), .i_op(op0),
    .i_a(a0), .i_b(b0), .o_c(c0), .o_f(f0), .o_valid(v0), .o_busy(bz0));

  cpu_alu_x #(.DW(16), .MPY_LATENCY(1), .OPT_EXTOPS(1'b1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce1), .i_abort(ab1), .i_op(op1),
    .i_a(a1), .i_b(b1), .o_c(c1), .o_f(f1), .o_valid(v1), .o_busy(bz1));

  cpu_alu_x #(.DW(16), .MPY_LATENCY(0), .OPT_EXTOPS(1'b0)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce2), .i_abort(ab2), .i_op(op2),
    .i_a(a2), .i_b(b2), .o_c(c2), .o_f(f2), .o_valid(v2), .o_busy(bz2));

  typedef struct packed { logic [31:0] c; logic [3:0] f; } exp_t;
  typedef struct packed { logic [3:0] op; logic [31:0] a, b, c; logic [3:0] f; } vec_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int checks = 0;
  int errors = 0;

  // Single-cycle vectors for u0 (DW=32), issued back to back; f = {V,N,C,Z}.
  localparam vec_t T0 [0:19] = '{
    {4'h0, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110},  // SUB borrow
    {4'h0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0001},  // SUB zero
    {4'h5, 32'h80000001, 32'h00000001, 32'h40000000, 4'b1010},  // LSR 1
    {4'h6, 32'h80000000, 32'h00000020, 32'h00000000, 4'b1011},  // LSL 32
    {4'h7, 32'h80000000, 32'h00000028, 32'hFFFFFFFF, 4'b0110},  // ASR 40
    {4'h1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000},  // AND
    {4'h3, 32'h12340000, 32'h00005678, 32'h12345678, 4'b0000},  // OR
    {4'h4, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000},  // XOR
    {4'h8, 32'h00000000, 32'h00000001, 32'h80000000, 4'b0100},  // BREV
    {4'h9, 32'hABCD1234, 32'h5678EF01, 32'hABCDEF01, 4'b0100},  // LODILO
    {4'hF, 32'h12345678, 32'h00000000, 32'h00000000, 4'b0001},  // MOV zero
    {4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0011},  // ADD carry
    {4'h6, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0000},  // LSL 0
    {4'h5, 32'hF0000000, 32'h00000021, 32'h00000000, 4'b1001},  // LSR 33
    {4'h7, 32'h80000000, 32'h00000020, 32'hFFFFFFFF, 4'b0110},  // ASR 32
    {4'h5, 32'h80000000, 32'h00000020, 32'h00000000, 4'b1011},  // LSR 32
    {4'h6, 32'h40000001, 32'h00000001, 32'h80000002, 4'b1100},  // LSL V
    {4'h0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100},  // SUB V
    {4'hD, 32'h80000001, 32'h00000021, 32'h00000003, 4'b0010},  // ROL 33
    {4'hE, 32'h00000000, 32'hFFFFFFFF, 32'h00000020, 4'b0000}   // POPC
  };

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one u0 request for a cycle; push the expected response if it should complete.
  task automatic issue0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] ec, input logic [3:0] ef);
    ce0 = 1'b1; op0 = op; a0 = a; b0 = b;
    if (push) q0.push_back(exp_t'({ec, ef}));
    @(negedge clk);
    ce0 = 1'b0;
  endtask

  task automatic issue16(input int u, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] ec, input logic [3:0] ef);
    if (u == 1) begin
      ce1 = 1'b1; op1 = op; a1 = a; b1 = b;
      q1.push_back(exp_t'({16'h0, ec, ef}));
    end else begin
      ce2 = 1'b1; op2 = op; a2 = a; b2 = b;
      q2.push_back(exp_t'({16'h0, ec, ef}));
    end
    @(negedge clk);
    ce1 = 1'b0; ce2 = 1'b0;
  endtask

  // Scoreboard monitors: every o_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (v0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_spurious_valid: got o_c=%h expected no o_valid", c0);
      end else begin
        e0 = q0.pop_front();
        chk("u0_result", {4'h0, c0, f0}, {4'h0, e0.c, e0.f});
      end
    end
  end

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_spurious_valid: got o_c=%h expected no o_valid", c1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_result", {20'h0, c1, f1}, {4'h0, e1.c, e1.f});
      end
    end
  end

  always @(negedge clk) begin
    if (v2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL u2_spurious_valid: got o_c=%h expected no o_valid", c2);
      end else begin
        e2 = q2.pop_front();
        chk("u2_result", {20'h0, c2, f2}, {4'h0, e2.c, e2.f});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("u0_reset", {2'b0, c0, f0, v0, bz0}, 40'h0);
    chk("u1_reset", {18'b0, c1, f1, v1, bz1}, 40'h0);
    chk("u2_reset", {18'b0, c2, f2, v2, bz2}, 40'h0);

    // Release reset and request on the very next rising edge.
    rst_n = 1'b1;
    issue0(4'h2, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 4'b1000);
    @(negedge clk);
    chk("u0_hold", {7'b0, v0, c0, f0}, {7'b0, 1'b0, 32'h80000000, 4'b1000});

    for (int i = 0; i < 20; i++)
      issue0(T0[i].op, T0[i].a, T0[i].b, 1'b1, T0[i].c, T0[i].f);
    repeat (2) @(negedge clk);

    // MPYSHI with L=3; a request during busy must be ignored.
    issue0(4'hB, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'hFFFFFFFF, 4'b0100);
    chk("busy_c1", {39'b0, bz0}, 40'h1);
    ce0 = 1'b1; op0 = 4'h2; a0 = 32'h1; b0 = 32'h1;
    @(negedge clk);
    chk("busy_c2", {39'b0, bz0}, 40'h1);
    ce0 = 1'b0;
    @(negedge clk);
    chk("busy_c3", {38'b0, bz0, v0}, 40'h1);

    // Abort one cycle after accept, with a simultaneous request that must be dropped.
    issue0(4'hC, 32'h00000005, 32'h00000007, 1'b0, 32'h0, 4'h0);
    ab0 = 1'b1; ce0 = 1'b1; op0 = 4'h2; a0 = 32'h1; b0 = 32'h1;
    @(negedge clk);
    ab0 = 1'b0; ce0 = 1'b0;
    chk("abort_idle", {38'b0, bz0, v0}, 40'h0);
    repeat (3) @(negedge clk);
    issue0(4'h2, 32'h00000002, 32'h00000003, 1'b1, 32'h00000005, 4'b0000);
    @(negedge clk);

    issue0(4'hA, 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'h00000001, 4'b0000);
    repeat (2) @(negedge clk);
    issue0(4'hC, 32'h00010000, 32'h00010000, 1'b1, 32'h00000000, 4'b0001);
    repeat (2) @(negedge clk);
    issue0(4'hC, 32'hFFFFFFFF, 32'h00000003, 1'b1, 32'hFFFFFFFD, 4'b0100);
    repeat (2) @(negedge clk);

    // 16-bit instances: extended ops, single-cycle multiply, extended ops disabled.
    issue16(1, 4'hE, 16'h0000, 16'hF0F1, 16'h0009, 4'b0000);
    issue16(1, 4'hD, 16'h8001, 16'h0011, 16'h0003, 4'b0010);
    issue16(1, 4'hB, 16'hFFFF, 16'h0002, 16'hFFFF, 4'b0100);
    issue16(1, 4'hD, 16'h1234, 16'h0010, 16'h1234, 4'b0000);
    issue16(2, 4'hD, 16'h1234, 16'h8001, 16'h8001, 4'b0100);
    issue16(2, 4'hE, 16'h0000, 16'hF0F1, 16'hF0F1, 4'b0100);
    issue16(2, 4'hA, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001);
    repeat (2) @(negedge clk);

    // Reset in the middle of a multiply clears outputs at once and yields no o_valid.
    chk("u0_prereset_hold", {8'b0, c0}, {8'b0, 32'hFFFFFFFD});
    issue0(4'hC, 32'h00000007, 32'h00000009, 1'b0, 32'h0, 4'h0);
    chk("rst_busy", {39'b0, bz0}, 40'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {2'b0, c0, f0, v0, bz0}, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue0(4'h2, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 4'b0000);
    repeat (3) @(negedge clk);

    chk("q0_drained", 40'(q0.size()), 40'h0);
    chk("q1_drained", 40'(q1.size()), 40'h0);
    chk("q2_drained", 40'(q2.size()), 40'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
